serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Processes DIGIT bits per clock, LSB first.
//  Uses one ripple full-adder slice plus a registered carry.
//  Computes A+B+cin or A-B-cin on WIDTH-bit operands with a start/done handshake.
//  Trades latency for area; the arithmetic core for later datapath and ALU blocks.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  1  bits processed per clock; STEPS = WIDTH/DIGIT cycles per operation
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; accepted only when ready=1
//  mode    in   1      0 = add, 1 = subtract; sampled with start
//  cin     in   1      carry-in (add) or borrow-in (sub); sampled with start
//  a       in   WIDTH  operand A; sampled with start
//  b       in   WIDTH  operand B; sampled with start
//  ready   out  1      1 when in IDLE and able to accept start
//  busy    out  1      1 while in RUN
//  done    out  1      1-cycle pulse: result/cout/ovf valid from this cycle
//  result  out  WIDTH  sum/difference; held until the next accepted start completes
//  cout    out  1      add: carry-out; sub: borrow-out (1 = A < B+cin unsigned)
//  ovf     out  1      signed (two's complement) overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0, internal regs=0.
//  FSM: IDLE -> RUN on start; RUN -> DONE after STEPS digit cycles; DONE -> IDLE unconditionally.
//  Accept: in IDLE at an edge with start=1, latch a, b, mode, cin.
//    Latch b' = mode ? ~b : b and carry0 = mode ? ~cin : cin; digit counter=0; go to RUN.
//  RUN: each edge adds digit i of A, digit i of b' and the carry reg (DIGIT-bit ripple).
//    Writes sum digit i into result, updates carry reg, increments counter.
//    The edge processing digit STEPS-1 moves to DONE.
//  Latency: start sampled at edge 0 -> done=1 in the cycle after edge STEPS; ready again after edge STEPS+1.
//  Throughput: one operation per STEPS+2 cycles.
//  Final flags on the last digit edge:
//    cout = mode ? ~c_msb_out : c_msb_out
//    ovf = carry into MSB XOR carry out of MSB
//  result/cout/ovf are undefined-free: bits not yet processed hold the previous value during RUN.
//    They are only architecturally valid from done onward.
//    Outputs stay stable from done until the next accepted start reaches its done.
//  start during RUN or DONE: ignored, not queued; operand inputs may change freely.
//  start held high continuously: a new operation is accepted at every IDLE cycle.
//  rst_n asserted mid-operation: abort immediately to reset values; no done pulse.
//  Arithmetic is modulo 2^WIDTH; no saturation. DIGIT=WIDTH gives single-cycle RUN (STEPS=1).
// TESTING
//  1 WIDTH=8,DIGIT=1: add FF+01,cin0 -> result 00, cout1, ovf0; done 9 cycles after start edge.
//  2 WIDTH=8,DIGIT=1: add 7F+01,cin0 -> result 80, cout0, ovf1; sub 80-01 -> 7F, cout0, ovf1.
//  3 WIDTH=8,DIGIT=4: sub 05-07,cin0 -> FE, cout1, ovf0; sub 05-04,cin1 -> 00, cout0; done after 3 cycles.
//  4 Start while busy: second start with a=11,b=22 during RUN is ignored.
//    First result holds; ready/busy/done sequence unchanged.
//  5 rst_n low at mid-RUN -> all outputs to reset values at once, no done.
//    Next start computes correctly.
//  6 WIDTH=4, DIGIT in {1,2,4}: exhaustive 2x2x16x16 (mode,cin,a,b) vs behavioural model.
//    Checks result, cout and ovf; one done per accepted start.

Source files
------------

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, through one ripple slice
// and a registered carry. The start/done handshake frames each operation.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   // state  | meaning
   // S_IDLE | waiting for start; ready=1
   // S_RUN  | one digit per clock through the ripple slice; busy=1
   // S_DONE | result/cout/ovf valid; done pulses for one cycle

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic              carry, mode_reg;
   logic [CW-1:0]     cnt;
   logic [DIGIT-1:0]  a_dig, b_dig, s_dig;
   logic [DIGIT:0]    chain;
   logic              accept, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   assign last = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // One DIGIT-wide ripple slice; chain[DIGIT-1] is the carry into the digit's top bit,
   // which on the last digit is the carry into the operand MSB.
   always_comb begin
      a_dig = a_reg[int'(cnt)*DIGIT +: DIGIT];
      b_dig = b_reg[int'(cnt)*DIGIT +: DIGIT];
      s_dig = '0;
      chain = '0;
      chain[0] = carry;
      for (int j = 0; j < DIGIT; j++) begin
         s_dig[j]   = a_dig[j] ^ b_dig[j] ^ chain[j];
         chain[j+1] = (a_dig[j] & b_dig[j]) | (chain[j] & (a_dig[j] ^ b_dig[j]));
      end
   end

   // Subtraction is A + ~B + ~cin, so the raw carry-out is the inverse of the borrow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         mode_reg <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         a_reg    <= a;
         b_reg    <= mode ? ~b : b;
         carry    <= mode ? ~cin : cin;
         mode_reg <= mode;
         cnt      <= '0;
      end else if (state == S_RUN) begin
         result[int'(cnt)*DIGIT +: DIGIT] <= s_dig;
         carry <= chain[DIGIT];
         cnt   <= cnt + 1'b1;
         if (last) begin
            cout <= mode_reg ^ chain[DIGIT];
            ovf  <= chain[DIGIT] ^ chain[DIGIT-1];
         end
      end
   end

endmodule
